// File: rtl/hd44780_pkg.sv
// Shared constants, scan FSM states and address helper for the HD44780 text buffer.
package hd44780_pkg;

  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] BLANK_CHAR    = 8'h20;
  localparam logic [7:0] ROW_BASE [4]  = '{8'h00, 8'h40, 8'h14, 8'h54};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_FETCH,
    S_WAIT,
    S_CHAR
  } scan_state_e;

  function automatic int unsigned lin_addr(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/hd44780_ram.sv
// Simple dual-port character RAM, synchronous read, read-before-write on collision.
module hd44780_ram
  import hd44780_pkg::*;
#(
  parameter int addr_width = 5,
  parameter int data_width = 8
) (
  input  logic                  wclk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic                  rclk,
  input  logic                  re,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  localparam int DEPTH = 1 << addr_width;

  // Contents come up blank and are deliberately outside the reset domain.
  logic [data_width-1:0] mem_q [DEPTH] = '{default: data_width'(BLANK_CHAR)};
  logic [data_width-1:0] rdata_q;

  always_ff @(posedge wclk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge rclk) begin
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hd44780_textbuf.sv
// HD44780 text buffer: cursor-addressed writes plus a handshaked DDRAM scan-out stream.
// Optional HD44780_DIRTY_EN skips the scan when nothing was written since the last one.
module hd44780_textbuf
  import hd44780_pkg::*;
#(
  parameter  int ROWS   = 2,
  parameter  int COLS   = 16,
  parameter  int DATA_W = 8,
  localparam int ADDR_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cur_set,
  input  logic [1:0]        cur_row,
  input  logic [5:0]        cur_col,
  output logic [ADDR_W-1:0] cursor,
  input  logic              refresh,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_cmd,
  output logic [7:0]        out_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);
  localparam logic [5:0]        LAST_COL  = 6'(COLS - 1);
  localparam logic [1:0]        LAST_ROW  = 2'(ROWS - 1);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [1:0]        row_q, row_d;
  logic [5:0]        col_q, col_d;
  logic              done_q, done_d;
  logic              go;
  logic              wr_accept;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign wr_accept = wr_valid && !cur_set;
  assign ram_raddr = ADDR_W'(lin_addr(32'(row_q), 32'(col_q), COLS));

  always_comb begin
    cursor_d = cursor_q;
    if (cur_set) begin
      if (32'(cur_row) < ROWS && 32'(cur_col) < COLS)
        cursor_d = ADDR_W'(lin_addr(32'(cur_row), 32'(cur_col), COLS));
    end else if (wr_valid) begin
      cursor_d = (cursor_q == LAST_ADDR) ? '0 : cursor_q + 1'b1;
    end
  end

`ifdef HD44780_DIRTY_EN
  logic dirty_q;

  // Reset marks dirty so the first refresh always paints the panel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         dirty_q <= 1'b1;
    else if (wr_accept) dirty_q <= 1'b1;
    else if (go)        dirty_q <= 1'b0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    done_d    = 1'b0;
    go        = 1'b0;
    ram_re    = 1'b0;
    out_valid = 1'b0;
    out_cmd   = 1'b0;
    out_data  = '0;
    case (state_q)
      S_IDLE: begin
`ifdef HD44780_DIRTY_EN
        if (refresh) begin
          if (dirty_q) go = 1'b1;
          else         done_d = 1'b1;
        end
`else
        go = refresh;
`endif
        if (go) begin
          state_d = S_CMD;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_CMD: begin
        out_valid = 1'b1;
        out_cmd   = 1'b1;
        out_data  = CMD_SET_DDRAM | ROW_BASE[row_q];
        if (out_ready) state_d = S_FETCH;
      end
      S_FETCH: begin
        ram_re  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: state_d = S_CHAR;
      S_CHAR: begin
        out_valid = 1'b1;
        out_data  = 8'(ram_rdata);
        if (out_ready) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = S_CMD;
            end
          end else begin
            col_d   = col_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cursor_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      row_q    <= row_d;
      col_q    <= col_d;
      done_q   <= done_d;
    end
  end

  hd44780_ram #(
    .addr_width(ADDR_W),
    .data_width(DATA_W)
  ) u_ram (
    .wclk  (clk),
    .we    (wr_accept),
    .waddr (cursor_q),
    .wdata (wr_data),
    .rclk  (clk),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign cursor = cursor_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_hd44780_textbuf.sv
// Directed bench for hd44780_textbuf (ROWS=2, COLS=16) with a stream scoreboard.
module tb_hd44780_textbuf;

  localparam int ROWS  = 2;
  localparam int COLS  = 16;
  localparam int DEPTH = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       cur_set = 1'b0;
  logic [1:0] cur_row = '0;
  logic [5:0] cur_col = '0;
  logic [4:0] cursor;
  logic       refresh = 1'b0;
  logic       busy, done, out_valid, out_cmd;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  hd44780_textbuf #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .DATA_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .cur_set  (cur_set),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .cursor   (cursor),
    .refresh  (refresh),
    .busy     (busy),
    .done     (done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cmd  (out_cmd),
    .out_data (out_data)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int extra_cnt = 0;
  int done_cnt = 0;
  int popped = 0;

  logic [8:0] exp_q [$];
  logic [7:0] mem_m [DEPTH];
  logic [7:0] base_m [4] = '{8'h00, 8'h40, 8'h14, 8'h54};
  int         cur_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) extra_cnt++;
        else begin
          chk("stream", {23'b0, out_cmd, out_data}, {23'b0, exp_q.pop_front()});
          popped++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    mem_m[cur_m] = d;
    cur_m = (cur_m + 1) % DEPTH;
  endtask

  task automatic set_cur(input int r, input int c);
    cur_set = 1'b1;
    cur_row = 2'(r);
    cur_col = 6'(c);
    tick();
    cur_set = 1'b0;
    if (r < ROWS && c < COLS) cur_m = r * COLS + c;
  endtask

  task automatic push_frame();
    for (int r = 0; r < ROWS; r++) begin
      exp_q.push_back({1'b1, 8'h80 | base_m[r]});
      for (int c = 0; c < COLS; c++) exp_q.push_back({1'b0, mem_m[r * COLS + c]});
    end
  endtask

  task automatic wait_scan(input string tag, input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 400), 1);
    tick();
    tick();
    chk({tag, "_done_pulses"}, done_cnt - start, 1);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    chk({tag, "_extra_words"}, extra_cnt, 0);
    chk({tag, "_busy_end"}, {31'b0, busy}, 0);
  endtask

  task automatic full_scan(input string tag);
    int start;
    start = done_cnt;
    extra_cnt = 0;
    push_frame();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    chk({tag, "_busy"}, {31'b0, busy}, 1);
    wait_scan(tag, start);
  endtask

  initial begin
    int start, n, base_pop;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h20;

    // Reset state
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_cmd", {31'b0, out_cmd}, 0);
    chk("rst_data", {24'b0, out_data}, 0);
    chk("rst_cursor", {27'b0, cursor}, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Basic write and full scan
    write_char(8'h48);
    write_char(8'h49);
    chk("cursor_after_writes", {27'b0, cursor}, 32'(cur_m));
    full_scan("scan1");
    chk("cursor_after_scan", {27'b0, cursor}, 2);

    // Cursor load at last cell, wrap on write
    set_cur(1, 15);
    chk("cursor_set", {27'b0, cursor}, 31);
    write_char(8'h41);
    write_char(8'h42);
    chk("cursor_wrap", {27'b0, cursor}, 1);
    full_scan("scan2");

    // Out-of-range cursor loads are ignored; cur_set beats wr_valid
    set_cur(2, 3);
    chk("cur_row_oob", {27'b0, cursor}, 32'(cur_m));
    set_cur(0, 16);
    chk("cur_col_oob", {27'b0, cursor}, 32'(cur_m));
    set_cur(0, 2);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    cur_set  = 1'b1;
    cur_row  = 2'd0;
    cur_col  = 6'd5;
    tick();
    wr_valid = 1'b0;
    cur_set  = 1'b0;
    cur_m    = 5;
    chk("set_wins_cursor", {27'b0, cursor}, 5);
    write_char(8'h5A);

    // Backpressure during CHAR, plus refresh while busy
    start = done_cnt;
    base_pop = popped;
    extra_cnt = 0;
    push_frame();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    n = 0;
    while (!(out_valid && !out_cmd && popped >= base_pop + 3) && n < 100) begin
      tick();
      n++;
    end
    chk("bp_reach", 32'(n < 100), 1);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 1);
      chk("bp_word", {23'b0, out_cmd, out_data}, {23'b0, exp_q[0]});
    end
    tick();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    out_ready = 1'b1;
    wait_scan("scan3", start);
    repeat (10) tick();
    chk("busy_refresh_ignored", done_cnt - start, 1);
    chk("busy_refresh_no_words", extra_cnt, 0);

    // Reset mid-scan
    base_pop = popped;
    push_frame();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    n = 0;
    while (popped < base_pop + 5 && n < 100) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_cursor", {27'b0, cursor}, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    cur_m = 0;
    tick();
    full_scan("scan4");

`ifdef HD44780_DIRTY_EN
    start = done_cnt;
    extra_cnt = 0;
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    chk("clean_done", {31'b0, done}, 1);
    chk("clean_busy", {31'b0, busy}, 0);
    repeat (5) tick();
    chk("clean_done_pulses", done_cnt - start, 1);
    chk("clean_no_words", extra_cnt, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hd44780_textbuf.md
HD44780_TEXTBUF -- requirements
Module: hd44780_textbuf

Interface
REQ-001 The block SHALL have parameter ROWS, default 2, number of display rows (1..4).
REQ-002 The block SHALL have parameter COLS, default 16, characters per row (1..40).
REQ-003 The block SHALL have parameter DATA_W, default 8, character width.
REQ-004 The block SHALL derive localparam ADDR_W = clog2(ROWS*COLS).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 wr_valid  in  1  write wr_data at cursor this cycle.
REQ-008 wr_data  in  DATA_W  character to write.
REQ-009 cur_set  in  1  load cursor from cur_row/cur_col.
REQ-010 cur_row  in  2  target row.
REQ-011 cur_col  in  6  target column.
REQ-012 cursor  out  ADDR_W  current linear write address.
REQ-013 refresh  in  1  start a full scan-out.
REQ-014 busy  out  1  scan-out in progress.
REQ-015 done  out  1  one-cycle pulse at scan completion.
REQ-016 out_valid  out  1  stream word valid.
REQ-017 out_ready  in  1  downstream accepts word.
REQ-018 out_cmd  out  1  1 = set-DDRAM-address command, 0 = character.
REQ-019 out_data  out  8  command byte or character.

Function
REQ-020 wr_valid SHALL write wr_data at cursor and increment cursor; cursor at ROWS*COLS-1 SHALL wrap to 0.
REQ-021 cur_set SHALL load cursor = cur_row*COLS+cur_col; cur_row>=ROWS or cur_col>=COLS SHALL leave cursor unchanged.
REQ-022 cur_set and wr_valid in the same cycle: cur_set wins, the write SHALL be dropped.
REQ-023 Scan FSM states: IDLE, CMD, FETCH, WAIT, CHAR; refresh in IDLE SHALL go to CMD with row=0, col=0, busy=1.
REQ-024 CMD SHALL present out_cmd=1, out_data=0x80|ROW_BASE[row]; on out_valid&&out_ready go to FETCH.
REQ-025 FETCH SHALL issue RAM read at row*COLS+col; WAIT SHALL cover the one-cycle RAM read latency; CHAR SHALL present out_cmd=0, out_data=RAM data.
REQ-026 On CHAR handshake: col++; col==COLS SHALL clear col and increment row; row==ROWS SHALL pulse done, clear busy, return to IDLE, else go to CMD.
REQ-027 While out_valid=1 and out_ready=0, out_data and out_cmd SHALL stay stable.
REQ-028 refresh while busy SHALL be ignored.
REQ-029 Writes during scan SHALL be accepted; same-address same-cycle write/read SHALL return old data.
REQ-030 RAM SHALL power up filled with 0x20 and SHALL NOT be cleared by rst_n.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, cursor=0, busy=0, done=0, out_valid=0, out_cmd=0, out_data=0, aborting any scan.

Configuration
REQ-032 With HD44780_DIRTY_EN defined, a dirty flag SHALL set on every accepted write and clear at scan start; refresh while clean SHALL pulse done on the next cycle with no stream transactions.
REQ-033 Without HD44780_DIRTY_EN, every accepted refresh SHALL perform a full scan.

Structure
REQ-034 Package hd44780_pkg SHALL hold ROW_BASE table {0x00,0x40,0x14,0x54}, CMD_SET_DDRAM=0x80 and FSM state encodings.
REQ-035 Storage SHALL be one hd44780_ram instance (addr_width=ADDR_W, data_width=DATA_W), wclk and rclk tied to clk.

Verification (ROWS=2, COLS=16)
REQ-036 Reset, write 0x48,0x49, refresh, out_ready=1 -> stream 0x80(cmd), 0x48, 0x49, 14x 0x20, 0xC0(cmd), 16x 0x20, done pulse; cursor=2.
REQ-037 cur_set row 1 col 15, write 0x41,0x42 -> 0x41 at address 31, 0x42 at address 0, cursor=1.
REQ-038 out_ready low 5 cycles during CHAR -> out_data/out_cmd unchanged, no extra words, then stream continues.
REQ-039 refresh while busy -> ignored; cur_set row 2 -> cursor unchanged.
REQ-040 rst_n low mid-scan -> out_valid=0 and busy=0 immediately, cursor=0; next refresh restarts with 0x80.
REQ-041 HD44780_DIRTY_EN, two refreshes without writes -> second gives done one cycle later, zero transactions.
